// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame defaults common to RX and TX.
`timescale 1ns/1ps
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line; resets to the idle (high) level.
`timescale 1ns/1ps
module uart_rx_sync (
  input  logic Clock,
  input  logic ResetN,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_d};
    end
  end

  assign o_q = r_sync[1];

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: oversampled mid-bit recovery of LSB-first frames with registered strobes.
// Optional parity bit is enabled by defining UART_RX_PARITY_EN.
`timescale 1ns/1ps
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 Tick,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] DataOut,
  output logic                 RxDone,
  output logic                 FrameErr,
  output logic                 ParityErr
);

  localparam int TC_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_BITS);
  localparam logic [TC_W-1:0] TC_MID  = TC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TC_W-1:0] TC_END  = TC_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

  uart_rx_state_e       r_state;
  logic [TC_W-1:0]      r_tc;
  logic [BC_W-1:0]      r_bc;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_done;
  logic                 r_ferr;
  logic                 w_rxs;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bad;
  logic                 r_perr;
`endif

  uart_rx_sync u_sync (
    .Clock  (Clock),
    .ResetN (ResetN),
    .i_d    (Rx),
    .o_q    (w_rxs)
  );

  // NOTE: all state uses non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_state   <= RX_IDLE;
      r_tc      <= '0;
      r_bc      <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr <= 1'b0;
`endif
      case (r_state)
        RX_IDLE: begin
          if (Tick && !w_rxs) begin
            r_tc    <= '0;
            r_state <= RX_START;
          end
        end
        RX_START: begin
          if (Tick) begin
            if (r_tc == TC_MID) begin
              if (!w_rxs) begin
                r_tc    <= '0;
                r_bc    <= '0;
                r_state <= RX_DATA;
              end else begin
                r_state <= RX_IDLE;
              end
            end else begin
              r_tc <= r_tc + 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (Tick) begin
            if (r_tc == TC_END) begin
              r_tc    <= '0;
              r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
              if (r_bc == BC_LAST) begin
`ifdef UART_RX_PARITY_EN
                r_state <= RX_PARITY;
`else
                r_state <= RX_STOP;
`endif
              end else begin
                r_bc <= r_bc + 1'b1;
              end
            end else begin
              r_tc <= r_tc + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (Tick) begin
            if (r_tc == TC_END) begin
              r_tc      <= '0;
              r_par_bad <= (w_rxs != (^r_shift ^ PARITY_ODD));
              r_state   <= RX_STOP;
            end else begin
              r_tc <= r_tc + 1'b1;
            end
          end
        end
`endif
        RX_STOP: begin
          if (Tick) begin
            if (r_tc == TC_END) begin
              // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
              r_tc    <= '0;
              r_state <= RX_IDLE;
              if (!w_rxs) begin
                r_ferr <= 1'b1;
`ifdef UART_RX_PARITY_EN
              end else if (r_par_bad) begin
                r_perr <= 1'b1;
`endif
              end else begin
                r_data <= r_shift;
                r_done <= 1'b1;
              end
            end else begin
              r_tc <= r_tc + 1'b1;
            end
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign DataOut  = r_data;
  assign RxDone   = r_done;
  assign FrameErr = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign ParityErr = r_perr;
`else
  // Parity sense is meaningless without a parity bit; the output is permanently low.
  assign ParityErr = PARITY_ODD & 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: good, glitch, framing-error, back-to-back, reset and parity frames.
`timescale 1ns/1ps
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int DB       = 8;
  localparam int OS       = 16;
  localparam int TICK_DIV = 24;
  localparam int BIT_CLKS = OS * TICK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic          Clock  = 1'b0;
  logic          ResetN = 1'b0;
  logic          Tick   = 1'b0;
  logic          Rx     = 1'b1;
  logic [DB-1:0] DataOut;
  logic          RxDone;
  logic          FrameErr;
  logic          ParityErr;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  logic [DB-1:0] rx_q[$];

  uart_receiver #(
    .DATA_BITS  (DB),
    .OVERSAMPLE (OS),
    .PARITY_ODD (1'b0)
  ) dut (
    .Clock     (Clock),
    .ResetN    (ResetN),
    .Tick      (Tick),
    .Rx        (Rx),
    .DataOut   (DataOut),
    .RxDone    (RxDone),
    .FrameErr  (FrameErr),
    .ParityErr (ParityErr)
  );

  always #10 Clock = ~Clock;

  initial begin
    forever begin
      repeat (TICK_DIV - 1) @(negedge Clock);
      Tick = 1'b1;
      @(negedge Clock);
      Tick = 1'b0;
    end
  end

  // Strobe monitor: counts every high cycle, so a stretched pulse shows up as extra counts.
  always @(negedge Clock) begin
    if (RxDone) begin
      done_cnt++;
      rx_q.push_back(DataOut);
    end
    if (FrameErr)  ferr_cnt++;
    if (ParityErr) perr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic line_bit(input logic b);
    @(negedge Clock);
    Rx = b;
    repeat (BIT_CLKS - 1) @(negedge Clock);
  endtask

  task automatic idle_bits(input int n);
    @(negedge Clock);
    Rx = 1'b1;
    repeat (n * BIT_CLKS) @(negedge Clock);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_b, input logic par_b);
    line_bit(1'b0);
    for (int i = 0; i < DB; i++) line_bit(d[i]);
    if (HAS_PAR) line_bit(par_b);
    line_bit(stop_b);
  endtask

  logic [DB-1:0] b55;

  initial begin
    repeat (5) @(negedge Clock);
    check("rst_dataout",  32'(DataOut),       32'h0);
    check("rst_rxdone",   32'(RxDone),        32'h0);
    check("rst_frameerr", 32'(FrameErr),      32'h0);
    check("rst_parerr",   32'(ParityErr),     32'h0);
    check("rst_state",    32'(dut.r_state),   32'(RX_IDLE));
    ResetN = 1'b1;
    idle_bits(1);

    // 1. good frame
    send_frame(8'hA5, 1'b1, ^8'hA5);
    idle_bits(1);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_dataout",  32'(DataOut),  32'hA5);
    check("t1_ferr_cnt", 32'(ferr_cnt), 32'd0);

    // 2. short low glitch shorter than half a bit
    @(negedge Clock);
    Rx = 1'b0;
    repeat (3 * TICK_DIV) @(negedge Clock);
    Rx = 1'b1;
    idle_bits(2);
    check("t2_state",    32'(dut.r_state), 32'(RX_IDLE));
    check("t2_done_cnt", 32'(done_cnt),    32'd1);
    check("t2_ferr_cnt", 32'(ferr_cnt),    32'd0);
    check("t2_dataout",  32'(DataOut),     32'hA5);

    // 3. bad stop bit
    send_frame(8'h3C, 1'b0, ^8'h3C);
    idle_bits(2);
    check("t3_ferr_cnt", 32'(ferr_cnt), 32'd1);
    check("t3_done_cnt", 32'(done_cnt), 32'd1);
    check("t3_dataout",  32'(DataOut),  32'hA5);
    check("t3_perr_cnt", 32'(perr_cnt), 32'd0);

    // 4. back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, ^8'h00);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    send_frame(8'h81, 1'b1, ^8'h81);
    idle_bits(1);
    check("t4_done_cnt", 32'(done_cnt), 32'd4);
    check("t4_q_size",   32'(rx_q.size()), 32'd4);
    check("t4_byte0",    32'(rx_q[1]),  32'h00);
    check("t4_byte1",    32'(rx_q[2]),  32'hFF);
    check("t4_byte2",    32'(rx_q[3]),  32'h81);
    check("t4_ferr_cnt", 32'(ferr_cnt), 32'd1);

    // 5. reset during bit 4 of 0x55, then a clean 0x12
    b55 = 8'h55;
    line_bit(1'b0);
    for (int i = 0; i < 4; i++) line_bit(b55[i]);
    @(negedge Clock);
    Rx = b55[4];
    repeat (BIT_CLKS / 2) @(negedge Clock);
    ResetN = 1'b0;
    Rx = 1'b1;
    repeat (10) @(negedge Clock);
    check("t5_rst_dataout", 32'(DataOut),     32'h0);
    check("t5_rst_state",   32'(dut.r_state), 32'(RX_IDLE));
    ResetN = 1'b1;
    idle_bits(2);
    check("t5_no_strobe",   32'(done_cnt),    32'd4);
    check("t5_no_ferr",     32'(ferr_cnt),    32'd1);
    send_frame(8'h12, 1'b1, ^8'h12);
    idle_bits(1);
    check("t5_done_cnt",    32'(done_cnt),    32'd5);
    check("t5_dataout",     32'(DataOut),     32'h12);
    check("t5_last_byte",   32'(rx_q[rx_q.size()-1]), 32'h12);

`ifdef UART_RX_PARITY_EN
    // 6. even parity: 0x07 has three ones, so the parity bit must be 1
    send_frame(8'h07, 1'b1, 1'b1);
    idle_bits(1);
    check("t6_good_done", 32'(done_cnt), 32'd6);
    check("t6_good_data", 32'(DataOut),  32'h07);
    check("t6_good_perr", 32'(perr_cnt), 32'd0);
    send_frame(8'h07, 1'b1, 1'b0);
    idle_bits(1);
    check("t6_bad_perr",  32'(perr_cnt), 32'd1);
    check("t6_bad_done",  32'(done_cnt), 32'd6);
    check("t6_bad_ferr",  32'(ferr_cnt), 32'd1);
`else
    check("t6_perr_cnt",  32'(perr_cnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
